// File: rtl/alu32_pkg.sv
// Shared encodings for the alu32 execute/memory stage: ALUOp classes,
// R-type funct codes, I-type opcodes and the 4-bit ALU control word.
package alu32_pkg;

  typedef logic [3:0] alu_ctrl_t;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_ANDI = 6'b001100;
  localparam logic [5:0] OPC_ORI  = 6'b001101;
  localparam logic [5:0] OPC_SLTI = 6'b001010;

  // Control word layout: [3] Ainvert, [2] Bnegate, [1:0] op select.
  localparam alu_ctrl_t ALU_AND = 4'b0000;
  localparam alu_ctrl_t ALU_OR  = 4'b0001;
  localparam alu_ctrl_t ALU_ADD = 4'b0010;
  localparam alu_ctrl_t ALU_SUB = 4'b0110;
  localparam alu_ctrl_t ALU_SLT = 4'b0111;
  localparam alu_ctrl_t ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

endpackage

// File: rtl/alu32_control.sv
// Combinational ALU control decode: ALUOp + funct + opcode -> control word.
// NOR decode is present only when ALU_NOR_EN is defined.
module alu32_control
  import alu32_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  input  logic [5:0] i_opcode,
  output alu_ctrl_t  o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_alu_op)
      ALUOP_MEM:    o_alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: o_alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD: o_alu_ctrl = ALU_ADD;
          FUNCT_SUB: o_alu_ctrl = ALU_SUB;
          FUNCT_AND: o_alu_ctrl = ALU_AND;
          FUNCT_OR:  o_alu_ctrl = ALU_OR;
          FUNCT_SLT: o_alu_ctrl = ALU_SLT;
`ifdef ALU_NOR_EN
          FUNCT_NOR: o_alu_ctrl = ALU_NOR;
`endif
          default:   o_alu_ctrl = ALU_ADD;
        endcase
      end
      ALUOP_ITYPE: begin
        case (i_opcode)
          OPC_ADDI: o_alu_ctrl = ALU_ADD;
          OPC_ANDI: o_alu_ctrl = ALU_AND;
          OPC_ORI:  o_alu_ctrl = ALU_OR;
          OPC_SLTI: o_alu_ctrl = ALU_SLT;
          default:  o_alu_ctrl = ALU_ADD;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu32.sv
// Execute/memory stage: ALU control decode, 32-bit ALU with flags and a
// word-organised data memory. Define ALU_NOR_EN to enable the NOR decode.
module alu32
  import alu32_pkg::*;
#(
  parameter int DMEM_WORDS = 64
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [1:0]  ALUOp,
  input  logic [5:0]  Funct,
  input  logic [5:0]  Opcode,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [3:0]  ALUCtrl,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        Overflow,
  output logic        CarryOut,
  output logic [31:0] ReadData
);

  localparam int AW = $clog2(DMEM_WORDS);

  alu_ctrl_t   w_ctrl;
  logic        w_ainv;
  logic        w_bneg;
  logic [1:0]  w_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [32:0] w_sum;
  logic        w_ovf;
  logic [31:0] w_result;
  logic [AW-1:0] w_index;

  logic [31:0] r_mem [DMEM_WORDS];

  alu32_control u_control (
    .i_alu_op  (ALUOp),
    .i_funct   (Funct),
    .i_opcode  (Opcode),
    .o_alu_ctrl(w_ctrl)
  );

  assign w_ainv = w_ctrl[3];
  assign w_bneg = w_ctrl[2];
  assign w_op   = w_ctrl[1:0];

  assign w_a   = w_ainv ? ~A : A;
  assign w_b   = w_bneg ? ~B : B;
  // Carry-in equals Bnegate so that a + ~b + 1 forms the two's-complement subtract.
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {32'b0, w_bneg};
  assign w_ovf = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);

  always_comb begin
    w_result = w_sum[31:0];
    case (w_op)
      OP_AND:  w_result = w_a & w_b;
      OP_OR:   w_result = w_a | w_b;
      OP_ADD:  w_result = w_sum[31:0];
      // Sign of the difference corrected by overflow gives true signed A < B.
      OP_SLT:  w_result = {31'b0, w_sum[31] ^ w_ovf};
      default: w_result = w_sum[31:0];
    endcase
  end

  assign ALUCtrl   = w_ctrl;
  assign ALUResult = w_result;
  assign Zero      = (w_result == 32'h0);
  assign Overflow  = w_ovf;
  assign CarryOut  = w_sum[32];

  // Byte address: low two bits and bits above the array size are dropped.
  assign w_index = w_result[AW+1:2];

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (MemWrite) begin
      r_mem[w_index] <= WriteData;
    end
  end

  assign ReadData = MemRead ? r_mem[w_index] : 32'h0;

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed decode/flag/memory cases plus
// randomized ALU and memory traffic against an arithmetic reference model.
module tb_alu32;

  localparam int DMEM_WORDS = 64;

  typedef enum int {R_AND, R_OR, R_ADD, R_SUB, R_SLT, R_NOR} ref_op_e;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [1:0]  ALUOp = 2'b00;
  logic [5:0]  Funct = 6'h0;
  logic [5:0]  Opcode = 6'h0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [3:0]  ALUCtrl;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;
  logic [31:0] ReadData;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] exp_mem [DMEM_WORDS];
  logic [31:0] exp_q[$];

  alu32 #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .ALUOp    (ALUOp),
    .Funct    (Funct),
    .Opcode   (Opcode),
    .A        (A),
    .B        (B),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ALUCtrl  (ALUCtrl),
    .ALUResult(ALUResult),
    .Zero     (Zero),
    .Overflow (Overflow),
    .CarryOut (CarryOut),
    .ReadData (ReadData)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  task automatic do_reset(input logic wr);
    @(negedge Clock);
    Reset_n   = 1'b0;
    MemWrite  = wr;
    MemRead   = 1'b0;
    ALUOp     = 2'b00;
    A         = 32'd8;
    B         = 32'd0;
    WriteData = 32'hA5A5_A5A5;
    @(posedge Clock);
    #1;
    Reset_n  = 1'b1;
    MemWrite = 1'b0;
    for (int i = 0; i < DMEM_WORDS; i++) exp_mem[i] = 32'h0;
  endtask

  // ---------------- reference model ----------------
  function automatic ref_op_e ref_decode(input logic [1:0] aluop, input logic [5:0] funct,
                                          input logic [5:0] opcode);
    ref_op_e op;
    op = R_ADD;
    if (aluop == 2'd1) op = R_SUB;
    else if (aluop == 2'd2) begin
      if (funct == 6'd32) op = R_ADD;
      else if (funct == 6'd34) op = R_SUB;
      else if (funct == 6'd36) op = R_AND;
      else if (funct == 6'd37) op = R_OR;
      else if (funct == 6'd42) op = R_SLT;
`ifdef ALU_NOR_EN
      else if (funct == 6'd39) op = R_NOR;
`endif
    end else if (aluop == 2'd3) begin
      if (opcode == 6'd8) op = R_ADD;
      else if (opcode == 6'd12) op = R_AND;
      else if (opcode == 6'd13) op = R_OR;
      else if (opcode == 6'd10) op = R_SLT;
    end
    return op;
  endfunction

  function automatic logic [3:0] ref_ctrl(input ref_op_e op);
    case (op)
      R_AND:   return 4'b0000;
      R_OR:    return 4'b0001;
      R_SUB:   return 4'b0110;
      R_SLT:   return 4'b0111;
      R_NOR:   return 4'b1100;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input ref_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      R_AND:   return a & b;
      R_OR:    return a | b;
      R_SUB:   return a - b;
      R_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      R_NOR:   return ~(a | b);
      default: return a + b;
    endcase
  endfunction

  // Overflow: true signed result leaves the 32-bit range.
  function automatic logic ref_ovf(input ref_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op == R_ADD) s = longint'($signed(a)) + longint'($signed(b));
    else s = longint'($signed(a)) - longint'($signed(b));
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Carry: unsigned add exceeds 32 bits; for subtract it is "no borrow" (a >= b).
  function automatic logic ref_carry(input ref_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned u;
    if (op == R_ADD) begin
      u = longint'(a) + longint'(b);
      return u > 64'hFFFF_FFFF;
    end
    return a >= b;
  endfunction

  function automatic int ref_index(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] addr;
    addr = a + b;
    return int'((addr >> 2) % DMEM_WORDS);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_alu(input logic [1:0] aluop, input logic [5:0] funct,
                           input logic [5:0] opcode, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clock);
    ALUOp = aluop; Funct = funct; Opcode = opcode; A = a; B = b;
    MemWrite = 1'b0; MemRead = 1'b0;
    #1;
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] b, input logic [31:0] data);
    @(negedge Clock);
    ALUOp = 2'b00; A = a; B = b; WriteData = data; MemWrite = 1'b1; MemRead = 1'b0;
    exp_mem[ref_index(a, b)] = data;
    @(posedge Clock);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic mem_read(input logic [31:0] a, input logic [31:0] b, input logic rd);
    @(negedge Clock);
    ALUOp = 2'b00; A = a; B = b; MemWrite = 1'b0; MemRead = rd;
    exp_q.push_back(rd ? exp_mem[ref_index(a, b)] : 32'h0);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [31:0] e;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      mem_read(32'(i * 4), 32'h0, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (ReadData !== e) begin
        n_fail++;
        $display("FAIL reset_read word%0d: got %08h expected %08h", i, ReadData, e);
      end
    end
  endtask

  task automatic test_decode;
    logic [17:0] tab [14];
    logic [3:0]  e;
    tab[0]  = {2'b00, 6'h00, 6'h00, 4'b0010};
    tab[1]  = {2'b01, 6'h00, 6'h00, 4'b0110};
    tab[2]  = {2'b10, 6'h20, 6'h00, 4'b0010};
    tab[3]  = {2'b10, 6'h22, 6'h00, 4'b0110};
    tab[4]  = {2'b10, 6'h24, 6'h00, 4'b0000};
    tab[5]  = {2'b10, 6'h25, 6'h00, 4'b0001};
    tab[6]  = {2'b10, 6'h2A, 6'h00, 4'b0111};
    tab[7]  = {2'b10, 6'h00, 6'h00, 4'b0010};
    tab[8]  = {2'b11, 6'h00, 6'h08, 4'b0010};
    tab[9]  = {2'b11, 6'h00, 6'h0C, 4'b0000};
    tab[10] = {2'b11, 6'h00, 6'h0D, 4'b0001};
    tab[11] = {2'b11, 6'h00, 6'h0A, 4'b0111};
    tab[12] = {2'b11, 6'h20, 6'h23, 4'b0010};
`ifdef ALU_NOR_EN
    tab[13] = {2'b10, 6'h27, 6'h00, 4'b1100};
`else
    tab[13] = {2'b10, 6'h27, 6'h00, 4'b0010};
`endif
    for (int i = 0; i < 14; i++) begin
      drive_alu(tab[i][17:16], tab[i][15:10], tab[i][9:4], 32'h1234, 32'h0042);
      e = tab[i][3:0];
      n_cmp++;
      if (ALUCtrl !== e) begin
        n_fail++;
        $display("FAIL decode row%0d: got %04b expected %04b", i, ALUCtrl, e);
      end
    end
  endtask

  task automatic test_add_sub_flags;
    drive_alu(2'b00, 6'h0, 6'h0, 32'h7FFF_FFFF, 32'h1);
    n_cmp++;
    if ({ALUResult, Overflow, CarryOut, Zero} !== {32'h8000_0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_pos_ovf: got res=%08h v=%b c=%b z=%b expected 80000000 v=1 c=0 z=0",
               ALUResult, Overflow, CarryOut, Zero);
    end
    drive_alu(2'b00, 6'h0, 6'h0, 32'hFFFF_FFFF, 32'h1);
    n_cmp++;
    if ({ALUResult, Overflow, CarryOut, Zero} !== {32'h0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL add_carry_zero: got res=%08h v=%b c=%b z=%b expected 00000000 v=0 c=1 z=1",
               ALUResult, Overflow, CarryOut, Zero);
    end
    drive_alu(2'b01, 6'h0, 6'h0, 32'd5, 32'd5);
    n_cmp++;
    if ({ALUResult, Zero} !== {32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_equal_zero: got res=%08h z=%b expected 00000000 z=1", ALUResult, Zero);
    end
    drive_alu(2'b01, 6'h0, 6'h0, 32'd3, 32'd5);
    n_cmp++;
    if ({ALUResult, Zero, CarryOut} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_borrow: got res=%08h z=%b c=%b expected fffffffe z=0 c=0",
               ALUResult, Zero, CarryOut);
    end
  endtask

  task automatic test_slt;
    drive_alu(2'b10, 6'h2A, 6'h0, 32'hFFFF_FFFE, 32'd3);
    n_cmp++;
    if (ALUResult !== 32'd1) begin
      n_fail++;
      $display("FAIL slt_neg_lt_pos: got %08h expected 00000001", ALUResult);
    end
    drive_alu(2'b10, 6'h2A, 6'h0, 32'h7FFF_FFFF, 32'h8000_0000);
    n_cmp++;
    if ({ALUResult, Zero} !== {32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL slt_ovf_corrected: got %08h z=%b expected 00000000 z=1", ALUResult, Zero);
    end
    drive_alu(2'b11, 6'h0, 6'h0A, 32'h8000_0000, 32'h7FFF_FFFF);
    n_cmp++;
    if (ALUResult !== 32'd1) begin
      n_fail++;
      $display("FAIL slti_min_lt_max: got %08h expected 00000001", ALUResult);
    end
  endtask

  task automatic test_logic;
    logic [31:0] e;
    drive_alu(2'b10, 6'h24, 6'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    n_cmp++;
    if (ALUResult !== 32'h00F0_00F0) begin
      n_fail++;
      $display("FAIL and: got %08h expected 00f000f0", ALUResult);
    end
    drive_alu(2'b10, 6'h25, 6'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    n_cmp++;
    if (ALUResult !== 32'hFFF0_FFF0) begin
      n_fail++;
      $display("FAIL or: got %08h expected fff0fff0", ALUResult);
    end
`ifdef ALU_NOR_EN
    e = 32'h000F_000F;
`else
    e = 32'hF0F0_F0F0 + 32'h0FF0_0FF0;
`endif
    drive_alu(2'b10, 6'h27, 6'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    n_cmp++;
    if (ALUResult !== e) begin
      n_fail++;
      $display("FAIL nor_funct: got %08h expected %08h", ALUResult, e);
    end
  endtask

  task automatic test_random_alu;
    logic [5:0]  functs  [7];
    logic [5:0]  opcodes [5];
    logic [1:0]  aluop;
    logic [5:0]  fn, oc;
    logic [31:0] a, b, er;
    ref_op_e     op;
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24; functs[3] = 6'h25;
    functs[4] = 6'h2A; functs[5] = 6'h27; functs[6] = 6'h00;
    opcodes[0] = 6'h08; opcodes[1] = 6'h0C; opcodes[2] = 6'h0D; opcodes[3] = 6'h0A;
    opcodes[4] = 6'h23;
    for (int i = 0; i < 300; i++) begin
      aluop = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 6)];
      oc = ($urandom_range(0, 3) == 0) ? 6'($urandom) : opcodes[$urandom_range(0, 4)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      drive_alu(aluop, fn, oc, a, b);
      op = ref_decode(aluop, fn, oc);
      er = ref_result(op, a, b);
      n_cmp++;
      if ({ALUCtrl, ALUResult, Zero} !== {ref_ctrl(op), er, er == 32'h0}) begin
        n_fail++;
        $display("FAIL rand_alu i=%0d op=%s a=%08h b=%08h: got ctrl=%04b res=%08h z=%b expected ctrl=%04b res=%08h z=%b",
                 i, op.name(), a, b, ALUCtrl, ALUResult, Zero, ref_ctrl(op), er, er == 32'h0);
      end
      if (op == R_ADD || op == R_SUB || op == R_SLT) begin
        n_cmp++;
        if ({Overflow, CarryOut} !== {ref_ovf(op, a, b), ref_carry(op, a, b)}) begin
          n_fail++;
          $display("FAIL rand_flags i=%0d op=%s a=%08h b=%08h: got v=%b c=%b expected v=%b c=%b",
                   i, op.name(), a, b, Overflow, CarryOut, ref_ovf(op, a, b), ref_carry(op, a, b));
        end
      end
    end
  endtask

  task automatic test_memory;
    logic [31:0] e;
    logic [31:0] addrs [4];
    logic        rds   [4];
    addrs[0] = 32'd8; addrs[1] = 32'd9; addrs[2] = 32'(8 + 4 * DMEM_WORDS); addrs[3] = 32'd8;
    rds[0] = 1'b1; rds[1] = 1'b1; rds[2] = 1'b1; rds[3] = 1'b0;
    mem_write(32'd8, 32'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      mem_read(addrs[i], 32'd0, rds[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if (ReadData !== e) begin
        n_fail++;
        $display("FAIL mem_load addr=%0d rd=%b: got %08h expected %08h", addrs[i], rds[i], ReadData, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    // Read and write the same word in one cycle: old word now, new word after the edge.
    mem_write(32'd20, 32'd0, 32'h1111_2222);
    @(negedge Clock);
    ALUOp = 2'b00; A = 32'd20; B = 32'd0; WriteData = 32'h3333_4444;
    MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    n_cmp++;
    if (ReadData !== 32'h1111_2222) begin
      n_fail++;
      $display("FAIL rw_same_old: got %08h expected 11112222", ReadData);
    end
    @(posedge Clock);
    #1;
    MemWrite = 1'b0;
    exp_mem[ref_index(32'd20, 32'd0)] = 32'h3333_4444;
    n_cmp++;
    if (ReadData !== 32'h3333_4444) begin
      n_fail++;
      $display("FAIL rw_same_new: got %08h expected 33334444", ReadData);
    end
  endtask

  task automatic test_random_mem;
    logic [31:0] a, b, e;
    for (int i = 0; i < 120; i++) begin
      a = $urandom;
      b = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        mem_write(a, b, $urandom);
      end else begin
        mem_read(a, b, ($urandom_range(0, 4) != 0));
        e = exp_q.pop_front();
        n_cmp++;
        if (ReadData !== e) begin
          n_fail++;
          $display("FAIL rand_mem i=%0d addr=%08h: got %08h expected %08h", i, a + b, ReadData, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] e;
    for (int i = 0; i < 6; i++) mem_write(32'(i * 4), 32'd0, 32'hC0DE_0000 + 32'(i));
    do_reset(1'b1);
    for (int i = 0; i < DMEM_WORDS; i++) begin
      mem_read(32'(i * 4), 32'd0, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (ReadData !== e) begin
        n_fail++;
        $display("FAIL reset_mid_clear word%0d: got %08h expected %08h", i, ReadData, e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < DMEM_WORDS; i++) exp_mem[i] = 32'h0;
    repeat (2) @(posedge Clock);
    test_reset();
    test_decode();
    test_add_sub_flags();
    test_slt();
    test_logic();
    test_random_alu();
    test_memory();
    test_back_to_back();
    test_random_mem();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu32.md
Name: alu32

Overview:
- Execute/memory stage of the single-cycle 32-bit MIPS-style datapath.
- Combines three functions:
  - ALU control decode: ALUOp + funct + opcode to a 4-bit control word.
  - 32-bit ALU: AND/OR/ADD/SUB/SLT/NOR with zero, overflow and carry flags.
  - Word-organised data memory: address from the ALU result, write data from register read port 2.
- Fed by the control unit and register file; drives the write-back mux and the branch AND gate.

Parameters:
- DMEM_WORDS, 64, number of 32-bit data-memory words; must be a power of two.

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  synchronous, active-low reset.
- ALUOp  in  2  class from control unit: 00 load/store, 01 branch, 10 R-type, 11 I-type.
- Funct  in  6  instruction[5:0].
- Opcode  in  6  instruction[31:26].
- A  in  32  operand A, register read data 1.
- B  in  32  operand B, register read data 2 or sign-extended immediate.
- WriteData  in  32  store data, register read data 2.
- MemWrite  in  1  store enable.
- MemRead  in  1  load enable.
- ALUCtrl  out  4  decoded control: [3] Ainvert, [2] Bnegate, [1:0] op (00 AND, 01 OR, 10 ADD, 11 SLT).
- ALUResult  out  32  ALU result; also the data-memory byte address.
- Zero  out  1  high when ALUResult == 0.
- Overflow  out  1  signed overflow of ADD/SUB/SLT.
- CarryOut  out  1  carry out of bit 31 of the adder.
- ReadData  out  32  load data.

Behaviour:
- Decode is purely combinational.
  - ALUOp 00: ADD (0010).
  - ALUOp 01: SUB (0110).
  - ALUOp 10, by Funct:
    - 100000 ADD 0010
    - 100010 SUB 0110
    - 100100 AND 0000
    - 100101 OR 0001
    - 101010 SLT 0111
    - 100111 NOR 1100
  - ALUOp 11, by Opcode:
    - 001000 addi: ADD
    - 001100 andi: AND
    - 001101 ori: OR
    - 001010 slti: SLT
  - Any unlisted code decodes to ADD (0010).
- ALU is combinational.
  - Operand a = Ainvert ? ~A : A; operand b = Bnegate ? ~B : B.
  - Carry-in = Bnegate.
  - Sum is 33 bits; CarryOut = sum[32].
  - Overflow = (a[31] == b[31]) && (sum[31] != a[31]).
  - op 00: a&b. op 01: a|b. op 10: sum.
  - op 11 (SLT): result = {31'b0, sum[31] ^ Overflow}, i.e. the correct signed A<B.
  - Overflow and CarryOut are driven for all ops and are meaningful only for the adder ops 10/11.
  - Zero is evaluated on the final ALUResult.
- Data memory organisation:
  - DMEM_WORDS x 32 bits.
  - Word index = ALUResult[log2(DMEM_WORDS)+1:2].
  - Bits [1:0] are ignored, so misaligned addresses are word-aligned down.
  - Upper address bits are ignored; addresses wrap modulo memory size.
- Write:
  - On rising Clock with Reset_n=1 and MemWrite=1, mem[index] <= WriteData.
  - Only one write per cycle.
- Read:
  - ReadData = MemRead ? mem[index] : 32'h0, combinational.
  - Simultaneous MemRead and MemWrite to the same index: ReadData shows the old word in that cycle and the new word after the edge.
- Reset:
  - Rising Clock with Reset_n=0 clears all memory words to 0.
  - MemWrite is ignored in that cycle.
  - ReadData therefore reads 0 after reset.
  - The ALU and decode have no state and are unaffected by reset.
  - Reset asserted mid-sequence discards all prior stores at the next edge.

Optional Feature:
- Macro ALU_NOR_EN.
- Defined: funct 100111 with ALUOp 10 decodes to NOR (1100, giving ~A & ~B).
- Undefined: funct 100111 decodes to the default ADD (0010), and ALUCtrl[3] is never set.

Decomposition:
- Package alu32_pkg holds:
  - localparams for ALUOp codes, funct codes and opcodes;
  - the 4-bit ALUCtrl encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR);
  - a typedef for the 4-bit control word.
- One sub-module, alu32_control, performs the decode.
- The ALU datapath and data memory stay in the top module.

Test Plan:
- Decode sweep: ALUOp 00/01 give 0010/0110. ALUOp 10 with funct 100000/100010/100100/100101/101010 gives 0010/0110/0000/0001/0111. ALUOp 11 with opcode 001000/001100/001101/001010 gives 0010/0000/0001/0111. ALUOp 10 with funct 000000 gives 0010.
- Add/sub flags:
  - 0x7FFFFFFF+1 gives 0x80000000, Overflow=1, CarryOut=0.
  - 0xFFFFFFFF+1 gives 0, Zero=1, CarryOut=1, Overflow=0.
  - SUB 5-5 gives 0, Zero=1.
- SLT signed: A=0xFFFFFFFE (-2), B=3 gives 1. A=0x7FFFFFFF, B=0x80000000 gives 0 (overflow-corrected).
- Logic: AND/OR of 0xF0F0F0F0 and 0x0FF00FF0 give 0x00F000F0 and 0xFFF0FFF0. With ALU_NOR_EN, NOR gives 0x000F000F.
- Memory store then load:
  - Store 0xDEADBEEF at address 8 (MemWrite=1, one edge).
  - Load from 8 gives 0xDEADBEEF; load from 9 also gives 0xDEADBEEF (low bits ignored).
  - Load from 8+4*DMEM_WORDS gives 0xDEADBEEF (wrap).
  - MemRead=0 gives ReadData=0.
- Reset: write several words, hold Reset_n=0 for one edge with MemWrite=1, then all loads read 0.
